multi_ch_dac_out: RTL

//  N-channel audio output stage. Replaces the per-channel ctrl + sigma_delta_2order_dac pairs.
//  - Generates staggered per-channel sample-rate triggers.
//  - Double-buffers samples arriving on one shared, channel-tagged bus.
//  - Drives one 2nd-order 1-bit sigma-delta modulator per channel.
//  - Sits between the generator/LPF chain and the PMOD DAC pins.

---
 rtl/multi_ch_dac_out_if.sv | 12 +
 rtl/multi_ch_dac_out.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/multi_ch_dac_out_if.sv
// Shared, channel-tagged sample bus feeding multi_ch_dac_out.
// The producer drives one tagged sample per smpl_in_rdy strobe.
interface multi_ch_dac_out_if #(
    parameter int SMPL_W = 18
) ();
    logic                     smpl_in_rdy;
    logic [3:0]               smpl_in_ch;
    logic signed [SMPL_W-1:0] smpl_in;

    modport master (output smpl_in_rdy, output smpl_in_ch, output smpl_in);
    modport slave  (input  smpl_in_rdy, input  smpl_in_ch, input  smpl_in);
endinterface

// File: rtl/multi_ch_dac_out.sv
// N-channel audio output: staggered sample triggers, double-buffered samples and one
// 2nd-order 1-bit sigma-delta per channel. DAC_UNDERRUN_ZERO_EN: underrun loads silence.
module multi_ch_dac_out_ch #(
    parameter int SMPL_W = 18
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trig_i,
    input  logic                     wr_i,
    input  logic signed [SMPL_W-1:0] smpl_i,
    output logic                     underrun_o,
    output logic                     dout_o
);
    localparam int AW = SMPL_W + 4;
    localparam int EW = AW + 2;
    localparam logic signed [EW-1:0] FS_E    = {{(EW-SMPL_W){1'b0}}, 1'b1, {(SMPL_W-1){1'b0}}};
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = -SAT_MAX;

    logic signed [SMPL_W-1:0] pend_q, pend_d, act_q, act_d;
    logic signed [AW-1:0]     acc1_q, acc1_d, acc2_q, acc2_d;
    logic signed [EW-1:0]     fb, sum1, sum2;
    logic                     fresh_q, fresh_d, und_q, und_d, dout_q, dout_d;

    function automatic logic signed [AW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[AW-1:0];
        else if (v < SAT_MIN) return SAT_MIN[AW-1:0];
        else                  return v[AW-1:0];
    endfunction

    always_comb begin
        pend_d  = pend_q;
        act_d   = act_q;
        fresh_d = fresh_q;
        und_d   = 1'b0;
        if (trig_i) begin
            fresh_d = 1'b0;
            // A write landing on the trigger cycle goes straight to the modulator.
            if (wr_i) begin
                act_d  = smpl_i;
                pend_d = smpl_i;
            end else begin
                und_d = !fresh_q;
`ifdef DAC_UNDERRUN_ZERO_EN
                act_d = fresh_q ? pend_q : '0;
`else
                act_d = pend_q;
`endif
            end
        end else if (wr_i) begin
            pend_d  = smpl_i;
            fresh_d = 1'b1;
        end

        fb     = dout_q ? FS_E : -FS_E;
        sum1   = EW'(acc1_q) + EW'(act_q) - fb;
        acc1_d = sat(sum1);
        sum2   = EW'(acc2_q) + EW'(acc1_d) - fb;
        acc2_d = sat(sum2);
        dout_d = !acc2_d[AW-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= '0;
            act_q   <= '0;
            fresh_q <= 1'b0;
            und_q   <= 1'b0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            dout_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            act_q   <= act_d;
            fresh_q <= fresh_d;
            und_q   <= und_d;
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            dout_q  <= dout_d;
        end
    end

    assign underrun_o = und_q;
    assign dout_o     = dout_q;
endmodule

module multi_ch_dac_out #(
    parameter int NUM_CH    = 2,
    parameter int SMPL_W    = 18,
    parameter int CLK_FREQ  = 100000000,
    parameter int SMPL_RATE = 48000
) (
    input  logic                clk,
    input  logic                reset_n,
    multi_ch_dac_out_if.slave   smpl_bus,
    output logic [NUM_CH-1:0]   smpl_rate_trig,
    output logic [NUM_CH-1:0]   underrun,
    output logic                err_bad_ch,
    output logic [NUM_CH-1:0]   dout
);
    localparam int PERIOD  = CLK_FREQ / SMPL_RATE;
    localparam int STAGGER = PERIOD / NUM_CH;
    localparam int CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] trig_q, trig_d, wr_sel;
    logic              err_q, err_d;

    always_comb begin
        cnt_d  = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
        trig_d = '0;
        wr_sel = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            trig_d[ch] = (cnt_q == CNT_W'(ch * STAGGER));
            wr_sel[ch] = smpl_bus.smpl_in_rdy && (smpl_bus.smpl_in_ch == 4'(ch));
        end
        err_d = smpl_bus.smpl_in_rdy && (32'(smpl_bus.smpl_in_ch) >= NUM_CH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            trig_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            trig_q <= trig_d;
            err_q  <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        multi_ch_dac_out_ch #(.SMPL_W(SMPL_W)) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .trig_i     (trig_q[g]),
            .wr_i       (wr_sel[g]),
            .smpl_i     (smpl_bus.smpl_in),
            .underrun_o (underrun[g]),
            .dout_o     (dout[g])
        );
    end

    assign smpl_rate_trig = trig_q;
    assign err_bad_ch     = err_q;
endmodule
